// File: rtl/gfx_pkg.sv
// Shared graphics types and display geometry for the drawing engines.
package gfx_pkg;

    localparam int CORDW       = 10;
    localparam int COLORW      = 4;
    localparam int DISP_WIDTH  = 640;
    localparam int DISP_HEIGHT = 480;

    typedef logic [CORDW-1:0]  coord_t;
    typedef logic [COLORW-1:0] color_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
        color_t color;
        logic   wait_flip;
    } rect_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_FLIP,
        ST_DRAW,
        ST_DONE
    } rect_state_e;

    function automatic coord_t clip_to(input coord_t v, input coord_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// Command handshake, flip pulse and pixel write port of rect_fill_engine.
interface rect_fill_engine_if;
    import gfx_pkg::*;

    logic   cmd_valid;
    logic   cmd_ready;
    coord_t cmd_x0;
    coord_t cmd_y0;
    coord_t cmd_x1;
    coord_t cmd_y1;
    color_t cmd_color;
    logic   cmd_wait_flip;
    logic   display_flip;

    coord_t wx;
    coord_t wy;
    color_t wc;
    logic   we;
    logic   busy;
    logic   done;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_wait_flip,
               display_flip,
        input  cmd_ready, wx, wy, wc, we, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_wait_flip,
               display_flip,
        output cmd_ready, wx, wy, wc, we, busy, done
    );

endinterface

// File: rtl/rect_raster_counter.sv
// Raster-order x/y walker over an already clipped, non-empty rectangle.
module rect_raster_counter
    import gfx_pkg::*;
(
    input  logic   clk_pix,
    input  logic   rst,
    input  logic   load,
    input  logic   advance,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t cx1,
    input  coord_t cy1,
    output coord_t x,
    output coord_t y,
    output logic   last
);

    coord_t x_start;
    coord_t x_end;
    coord_t y_end;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            x_start <= '0;
            x_end   <= '0;
            y_end   <= '0;
        end else if (load) begin
            x       <= x0;
            y       <= y0;
            x_start <= x0;
            x_end   <= cx1;
            y_end   <= cy1;
        end else if (advance) begin
            if (x == x_end) begin
                x <= x_start;
                y <= y + coord_t'(1);
            end else begin
                x <= x + coord_t'(1);
            end
        end
    end

    assign last = (x == x_end) && (y == y_end);

endmodule

// File: rtl/rect_fill_engine.sv
// Filled-rectangle engine: accepts a command, clips it to the display and
// streams one pixel write per clock in raster order.
module rect_fill_engine
    import gfx_pkg::*;
(
    input logic          clk_pix,
    input logic          rst,
    rect_fill_engine_if.slave bus
);

    localparam coord_t X_MAX = coord_t'(DISP_WIDTH - 1);
    localparam coord_t Y_MAX = coord_t'(DISP_HEIGHT - 1);

    rect_state_e state;
    rect_state_e state_next;
    rect_cmd_t   cmd;
    coord_t      cx1;
    coord_t      cy1;
    logic        empty;
    logic        accept;
    logic        cnt_load;
    logic        cnt_advance;
    logic        cnt_last;

    assign accept = bus.cmd_valid && bus.cmd_ready;

    assign cx1   = clip_to(cmd.x1, X_MAX);
    assign cy1   = clip_to(cmd.y1, Y_MAX);
    assign empty = (cmd.x0 > cx1) || (cmd.y0 > cy1) || (cmd.x0 > X_MAX) || (cmd.y0 > Y_MAX);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next  = state;
        cnt_load    = 1'b0;
        cnt_advance = 1'b0;
        unique case (state)
            ST_IDLE:      if (accept) state_next = ST_SETUP;
            ST_SETUP: begin
                if (empty)              state_next = ST_DONE;
                else if (cmd.wait_flip) state_next = ST_WAIT_FLIP;
                else                    state_next = ST_DRAW;
            end
            ST_WAIT_FLIP: if (bus.display_flip) state_next = ST_DRAW;
            ST_DRAW: begin
                cnt_advance = !cnt_last;
                if (cnt_last) state_next = ST_DONE;
            end
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
        // Load on entry to DRAW only, so wx/wy keep their last values while waiting.
        cnt_load = (state != ST_DRAW) && (state_next == ST_DRAW);
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cmd           <= '0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.we        <= 1'b0;
            bus.wc        <= '0;
        end else begin
            state         <= state_next;
            bus.cmd_ready <= (state_next == ST_IDLE);
            bus.busy      <= (state_next != ST_IDLE);
            bus.done      <= (state_next == ST_DONE);
            bus.we        <= (state_next == ST_DRAW);
            if (accept) begin
                cmd <= '{x0: bus.cmd_x0, y0: bus.cmd_y0, x1: bus.cmd_x1, y1: bus.cmd_y1,
                         color: bus.cmd_color, wait_flip: bus.cmd_wait_flip};
            end
            if (cnt_load) bus.wc <= cmd.color;
        end
    end

    rect_raster_counter u_counter (
        .clk_pix (clk_pix),
        .rst     (rst),
        .load    (cnt_load),
        .advance (cnt_advance),
        .x0      (cmd.x0),
        .y0      (cmd.y0),
        .cx1     (cx1),
        .cy1     (cy1),
        .x       (bus.wx),
        .y       (bus.wy),
        .last    (cnt_last)
    );

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine against a cycle-level rectangle model.
module tb_rect_fill_engine;
    import gfx_pkg::*;

    typedef struct {
        int x;
        int y;
    } pix_t;

    logic clk_pix = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rect_fill_engine_if bus ();

    rect_fill_engine dut (
        .clk_pix (clk_pix),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_pix = ~clk_pix;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic rect_cmd_t mk_cmd(input int x0, input int y0, input int x1,
                                         input int y1, input int col, input bit wf);
        rect_cmd_t c;
        c.x0        = coord_t'(x0);
        c.y0        = coord_t'(y0);
        c.x1        = coord_t'(x1);
        c.y1        = coord_t'(y1);
        c.color     = color_t'(col);
        c.wait_flip = wf;
        return c;
    endfunction

    task automatic drive_cmd(input rect_cmd_t c);
        bus.cmd_x0        = c.x0;
        bus.cmd_y0        = c.y0;
        bus.cmd_x1        = c.x1;
        bus.cmd_y1        = c.y1;
        bus.cmd_color     = c.color;
        bus.cmd_wait_flip = c.wait_flip;
        bus.cmd_valid     = 1'b1;
    endtask

    // Runs one command in lockstep with the model. Flip pulses are given as cycle
    // offsets from the accept cycle (-1 = none). With hold_next the next command is
    // presented from the cycle after accept and cmd_valid stays high.
    task automatic exec_cmd(input string name, input rect_cmd_t c, input int flip_a,
                            input int flip_b, input bit hold_next, input rect_cmd_t nxt);
        pix_t exp_q[$];
        pix_t p;
        int   cx1, cy1, n, start, done_rel, waited;
        logic exp_we;

        cx1 = (int'(c.x1) > DISP_WIDTH - 1) ? DISP_WIDTH - 1 : int'(c.x1);
        cy1 = (int'(c.y1) > DISP_HEIGHT - 1) ? DISP_HEIGHT - 1 : int'(c.y1);
        for (int y = int'(c.y0); y <= cy1; y++)
            for (int x = int'(c.x0); x <= cx1; x++)
                exp_q.push_back('{x: x, y: y});
        n = exp_q.size();

        start = 2;
        if (n > 0 && c.wait_flip) begin
            start = -1;
            if (flip_a >= 2) start = flip_a + 1;
            if (flip_b >= 2 && (start < 0 || flip_b + 1 < start)) start = flip_b + 1;
        end
        done_rel = (n == 0) ? 2 : start + n;

        bus.display_flip = 1'b0;
        drive_cmd(c);
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk_pix);
            waited++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: cmd_ready=%b after %0d cycles, required 1", name,
                     bus.cmd_ready, waited);
            bus.cmd_valid = 1'b0;
            return;
        end
        bus.display_flip = (flip_a == 0);

        for (int r = 1; r <= done_rel + 1; r++) begin
            @(negedge clk_pix);
            if (r == 1) begin
                if (hold_next) drive_cmd(nxt);
                else bus.cmd_valid = 1'b0;
            end
            bus.display_flip = (r == flip_a) || (r == flip_b);
            exp_we = (n > 0) && (r >= start) && (r < start + n);

            checks++;
            if (bus.we !== exp_we) begin
                errors++;
                $display("FAIL %s we r=%0d: got %b, required %b", name, r, bus.we, exp_we);
            end
            if (exp_we) begin
                p = exp_q[r - start];
                checks++;
                if (bus.wx !== coord_t'(p.x) || bus.wy !== coord_t'(p.y) || bus.wc !== c.color) begin
                    errors++;
                    $display("FAIL %s pixel r=%0d: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)",
                             name, r, bus.wx, bus.wy, bus.wc, p.x, p.y, c.color);
                end
            end
            checks++;
            if (bus.done !== (r == done_rel)) begin
                errors++;
                $display("FAIL %s done r=%0d: got %b, required %b", name, r, bus.done, r == done_rel);
            end
            checks++;
            if (bus.cmd_ready !== (r == done_rel + 1)) begin
                errors++;
                $display("FAIL %s cmd_ready r=%0d: got %b, required %b", name, r, bus.cmd_ready,
                         r == done_rel + 1);
            end
            checks++;
            if (bus.busy !== (r <= done_rel)) begin
                errors++;
                $display("FAIL %s busy r=%0d: got %b, required %b", name, r, bus.busy, r <= done_rel);
            end
        end
        bus.display_flip = 1'b0;
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_pix);
            checks++;
            if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s idle: we=%b busy=%b ready=%b done=%b, required 0 0 1 0", name,
                         bus.we, bus.busy, bus.cmd_ready, bus.done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_cmd(mk_cmd(1, 1, 2, 2, 1, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pix);
            checks++;
            if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 ||
                bus.wx !== '0 || bus.wy !== '0 || bus.wc !== '0) begin
                errors++;
                $display("FAIL reset values: we=%b busy=%b done=%b ready=%b wx=%0d wy=%0d wc=%0d, required 0 0 0 1 0 0 0",
                         bus.we, bus.busy, bus.done, bus.cmd_ready, bus.wx, bus.wy, bus.wc);
            end
        end
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        check_idle("after_reset", 3);
    endtask

    task automatic test_basic();
        exec_cmd("basic", mk_cmd(10, 20, 11, 21, 5, 0), -1, -1, 1'b0, mk_cmd(0, 0, 0, 0, 0, 0));
        exec_cmd("single_pixel", mk_cmd(639, 479, 639, 479, 15, 0), -1, -1, 1'b0, mk_cmd(0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_clipping();
        exec_cmd("clip", mk_cmd(630, 470, 700, 500, 3, 0), -1, -1, 1'b0, mk_cmd(0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_empty();
        exec_cmd("empty_inverted", mk_cmd(50, 50, 40, 60, 7, 0), -1, -1, 1'b0, mk_cmd(0, 0, 0, 0, 0, 0));
        exec_cmd("empty_offscreen", mk_cmd(700, 10, 710, 12, 2, 1), 5, 6, 1'b0, mk_cmd(0, 0, 0, 0, 0, 0));
        exec_cmd("empty_below", mk_cmd(5, 480, 8, 490, 9, 0), -1, -1, 1'b0, mk_cmd(0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_wait_flip();
        exec_cmd("wait_flip", mk_cmd(0, 0, 3, 0, 9, 1), 1, 10, 1'b0, mk_cmd(0, 0, 0, 0, 0, 0));
        exec_cmd("flip_in_accept", mk_cmd(4, 4, 5, 5, 11, 1), 0, 7, 1'b0, mk_cmd(0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_back_to_back();
        rect_cmd_t a, b;
        a = mk_cmd(100, 100, 102, 101, 4, 0);
        b = mk_cmd(200, 5, 200, 7, 12, 0);
        exec_cmd("b2b_first", a, -1, -1, 1'b1, b);
        exec_cmd("b2b_second", b, -1, -1, 1'b0, a);
        check_idle("b2b_no_dup", 4);
    endtask

    task automatic test_random();
        rect_cmd_t cmds[25];
        int        x0, y0, x1, y1;
        for (int i = 0; i < 25; i++) begin
            x0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(620, 700)) : int'($urandom_range(0, 639));
            y0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(460, 520)) : int'($urandom_range(0, 479));
            x1 = x0 + int'($urandom_range(0, 12));
            y1 = y0 + int'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0 && x0 >= 5) x1 = x0 - 5;
            if ($urandom_range(0, 7) == 0 && y0 >= 5) y1 = y0 - 5;
            cmds[i] = mk_cmd(x0, y0, x1, y1, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 25; i++) begin
            exec_cmd($sformatf("rand%0d", i), cmds[i], int'($urandom_range(0, 2)),
                     int'($urandom_range(2, 15)), (i < 24) && ($urandom_range(0, 1) == 1),
                     cmds[(i + 1) % 25]);
        end
        bus.cmd_valid = 1'b0;
        check_idle("rand_end", 2);
    endtask

    task automatic test_reset_mid_draw();
        int wr, waited;
        bus.display_flip = 1'b0;
        drive_cmd(mk_cmd(0, 0, 9, 9, 6, 0));
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk_pix);
            waited++;
        end
        @(negedge clk_pix);
        bus.cmd_valid = 1'b0;
        wr = 0;
        waited = 0;
        while (wr < 20 && waited < 100) begin
            if (bus.we === 1'b1) wr++;
            if (wr < 20) begin
                @(negedge clk_pix);
                waited++;
            end
        end
        checks++;
        if (wr != 20 || bus.wx !== coord_t'(9) || bus.wy !== coord_t'(1)) begin
            errors++;
            $display("FAIL mid_draw 20th write: count=%0d at (%0d,%0d), required 20 at (9,1)",
                     wr, bus.wx, bus.wy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.wx !== '0 || bus.wy !== '0 ||
            bus.wc !== '0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_draw async reset: we=%b busy=%b wx=%0d wy=%0d wc=%0d done=%b, required 0 0 0 0 0 0",
                     bus.we, bus.busy, bus.wx, bus.wy, bus.wc, bus.done);
        end
        drive_cmd(mk_cmd(3, 3, 4, 4, 1, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pix);
            checks++;
            if (bus.we !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_draw held reset: we=%b busy=%b, required 0 0", bus.we, bus.busy);
            end
        end
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        check_idle("mid_draw_release", 3);
    endtask

    initial begin
        rst               = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_x0        = '0;
        bus.cmd_y0        = '0;
        bus.cmd_x1        = '0;
        bus.cmd_y1        = '0;
        bus.cmd_color     = '0;
        bus.cmd_wait_flip = 1'b0;
        bus.display_flip  = 1'b0;
        @(negedge clk_pix);

        test_reset();
        test_basic();
        test_clipping();
        test_empty();
        test_wait_flip();
        test_back_to_back();
        test_random();
        test_reset_mid_draw();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
